// File: rtl/stat_window_eval.sv
// Window statistics evaluator: sums per-word stats over 2^WIN_LOG2 words, checks thresholds, reports via valid/ready.
// Optional macro STAT_WIN_AUTO_RESTART_EN: restart the next window right after an accepted report.
module stat_window_eval #(
  parameter int WORD_SIZE = 256,
  parameter int BIT_RES   = $clog2(WORD_SIZE),
  parameter int WIN_LOG2  = 10,
  parameter int ACC_W     = BIT_RES + WIN_LOG2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stat_valid,
  input  logic [BIT_RES-1:0] ones,
  input  logic [BIT_RES-1:0] change_sign_count,
  input  logic [BIT_RES-1:0] ones_max_len,
  input  logic [BIT_RES-1:0] zeros_max_len,
  input  logic [ACC_W-1:0]   ones_sum_lo,
  input  logic [ACC_W-1:0]   ones_sum_hi,
  input  logic [ACC_W-1:0]   chg_sum_lo,
  input  logic [BIT_RES-1:0] run_limit,
  output logic               busy,
  output logic [WIN_LOG2-1:0] word_cnt,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [ACC_W-1:0]   rpt_ones_sum,
  output logic [ACC_W-1:0]   rpt_chg_sum,
  output logic [BIT_RES-1:0] rpt_max_run,
  output logic [2:0]         rpt_fail_flags,
  output logic               rpt_fail,
  output logic               overrun,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_EVAL   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  // Report handshake: a report transfers on any cycle with rpt_valid & rpt_ready;
  // rpt_valid never drops and rpt_* never change before that cycle.
  state_t               r_state;
  state_t               w_next;
  logic [ACC_W-1:0]     r_ones_acc;
  logic [ACC_W-1:0]     r_chg_acc;
  logic [BIT_RES-1:0]   r_max_run;
  logic [WIN_LOG2-1:0]  r_word_cnt;
  logic                 r_overrun;
  logic [ACC_W-1:0]     r_rpt_ones;
  logic [ACC_W-1:0]     r_rpt_chg;
  logic [BIT_RES-1:0]   r_rpt_max;
  logic [2:0]           r_rpt_flags;
  logic                 r_rpt_fail;
  logic                 w_last;
  logic [BIT_RES-1:0]   w_run_max;
  logic [2:0]           w_flags;

  assign w_last = (r_word_cnt == {WIN_LOG2{1'b1}});

  always_comb begin
    w_run_max = r_max_run;
    if (ones_max_len > w_run_max)  w_run_max = ones_max_len;
    if (zeros_max_len > w_run_max) w_run_max = zeros_max_len;
  end

  always_comb begin
    w_flags    = 3'b000;
    w_flags[0] = (r_ones_acc < ones_sum_lo) || (r_ones_acc > ones_sum_hi);
    w_flags[1] = (r_max_run > run_limit);
    w_flags[2] = (r_chg_acc < chg_sum_lo);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ACCUM;
      S_ACCUM:  if (stat_valid && w_last) w_next = S_EVAL;
      S_EVAL:   w_next = S_REPORT;
      S_REPORT: begin
        if (rpt_ready) begin
`ifdef STAT_WIN_AUTO_RESTART_EN
          w_next = S_ACCUM;
`else
          w_next = S_IDLE;
`endif
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones_acc  <= '0;
      r_chg_acc   <= '0;
      r_max_run   <= '0;
      r_word_cnt  <= '0;
      r_overrun   <= 1'b0;
      r_rpt_ones  <= '0;
      r_rpt_chg   <= '0;
      r_rpt_max   <= '0;
      r_rpt_flags <= 3'b000;
      r_rpt_fail  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ones_acc <= '0;
            r_chg_acc  <= '0;
            r_max_run  <= '0;
            r_word_cnt <= '0;
            r_overrun  <= 1'b0;
          end
        end
        S_ACCUM: begin
          // word_cnt wraps to 0 naturally on the last word of the window
          if (stat_valid) begin
            r_ones_acc <= r_ones_acc + {{(ACC_W-BIT_RES){1'b0}}, ones};
            r_chg_acc  <= r_chg_acc + {{(ACC_W-BIT_RES){1'b0}}, change_sign_count};
            r_max_run  <= w_run_max;
            r_word_cnt <= r_word_cnt + 1'b1;
          end
        end
        S_EVAL: begin
          r_rpt_ones  <= r_ones_acc;
          r_rpt_chg   <= r_chg_acc;
          r_rpt_max   <= r_max_run;
          r_rpt_flags <= w_flags;
          r_rpt_fail  <= |w_flags;
        end
        S_REPORT: begin
`ifdef STAT_WIN_AUTO_RESTART_EN
          if (rpt_ready) begin
            r_ones_acc <= '0;
            r_chg_acc  <= '0;
            r_max_run  <= '0;
            r_word_cnt <= '0;
          end
`endif
        end
        default: ;
      endcase
      if (stat_valid && (r_state == S_EVAL || r_state == S_REPORT))
        r_overrun <= 1'b1;
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign word_cnt       = r_word_cnt;
  assign rpt_valid      = (r_state == S_REPORT);
  assign rpt_ones_sum   = r_rpt_ones;
  assign rpt_chg_sum    = r_rpt_chg;
  assign rpt_max_run    = r_rpt_max;
  assign rpt_fail_flags = r_rpt_flags;
  assign rpt_fail       = r_rpt_fail;
  assign overrun        = r_overrun;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_stat_window_eval.sv
// Directed bench for stat_window_eval with a 4-word window (WIN_LOG2=2, ACC_W=10).
module tb_stat_window_eval;
  localparam int WORD_SIZE = 256;
  localparam int BIT_RES   = 8;
  localparam int WIN_LOG2  = 2;
  localparam int ACC_W     = 10;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stat_valid;
  logic [BIT_RES-1:0] ones;
  logic [BIT_RES-1:0] change_sign_count;
  logic [BIT_RES-1:0] ones_max_len;
  logic [BIT_RES-1:0] zeros_max_len;
  logic [ACC_W-1:0]   ones_sum_lo;
  logic [ACC_W-1:0]   ones_sum_hi;
  logic [ACC_W-1:0]   chg_sum_lo;
  logic [BIT_RES-1:0] run_limit;
  logic               busy;
  logic [WIN_LOG2-1:0] word_cnt;
  logic               rpt_valid;
  logic               rpt_ready;
  logic [ACC_W-1:0]   rpt_ones_sum;
  logic [ACC_W-1:0]   rpt_chg_sum;
  logic [BIT_RES-1:0] rpt_max_run;
  logic [2:0]         rpt_fail_flags;
  logic               rpt_fail;
  logic               overrun;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  stat_window_eval #(
    .WORD_SIZE(WORD_SIZE), .BIT_RES(BIT_RES), .WIN_LOG2(WIN_LOG2), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stat_valid(stat_valid),
    .ones(ones), .change_sign_count(change_sign_count),
    .ones_max_len(ones_max_len), .zeros_max_len(zeros_max_len),
    .ones_sum_lo(ones_sum_lo), .ones_sum_hi(ones_sum_hi),
    .chg_sum_lo(chg_sum_lo), .run_limit(run_limit),
    .busy(busy), .word_cnt(word_cnt), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_ones_sum(rpt_ones_sum), .rpt_chg_sum(rpt_chg_sum), .rpt_max_run(rpt_max_run),
    .rpt_fail_flags(rpt_fail_flags), .rpt_fail(rpt_fail), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] o, input logic [7:0] c,
                        input logic [7:0] om, input logic [7:0] zm);
    ones = o; change_sign_count = c; ones_max_len = om; zeros_max_len = zm;
    stat_valid = 1'b1;
    tick();
    stat_valid = 1'b0;
  endtask

  task automatic run_window(input string tag, input logic [7:0] o, input logic [7:0] c,
                            input logic [7:0] om2, input logic [9:0] e_ones,
                            input logic [9:0] e_chg, input logic [7:0] e_max,
                            input logic [2:0] e_flags);
    pulse_start();
    check({tag, "_busy"}, busy, 1);
    check({tag, "_cnt0"}, word_cnt, 0);
    for (int w = 0; w < 4; w++) strobe(o, c, (w == 1) ? om2 : 8'd3, 8'd4);
    check({tag, "_eval_novalid"}, rpt_valid, 0);
    tick();
    check({tag, "_valid"}, rpt_valid, 1);
    check({tag, "_ones"}, rpt_ones_sum, e_ones);
    check({tag, "_chg"}, rpt_chg_sum, e_chg);
    check({tag, "_max"}, rpt_max_run, e_max);
    check({tag, "_flags"}, rpt_fail_flags, e_flags);
    check({tag, "_fail"}, rpt_fail, (e_flags != 3'b000));
  endtask

  task automatic end_report(input string tag);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    check({tag, "_drop"}, rpt_valid, 0);
`ifdef STAT_WIN_AUTO_RESTART_EN
    check({tag, "_restart"}, dbg_state, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`else
    check({tag, "_idle"}, busy, 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stat_valid = 1'b0; rpt_ready = 1'b0;
    ones = '0; change_sign_count = '0; ones_max_len = '0; zeros_max_len = '0;
    ones_sum_lo = 10'd480; ones_sum_hi = 10'd544; chg_sum_lo = 10'd300; run_limit = 8'd8;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_cnt", word_cnt, 0);
    check("rst_valid", rpt_valid, 0);
    check("rst_ones", rpt_ones_sum, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // nominal window, then range/run/change violations
    run_window("t1", 8'd128, 8'd100, 8'd3, 10'd512, 10'd400, 8'd4, 3'b000);
    end_report("t1");
`ifndef STAT_WIN_AUTO_RESTART_EN
    check("t1_retain", rpt_ones_sum, 512);
`endif
    run_window("t2a", 8'd200, 8'd100, 8'd3, 10'd800, 10'd400, 8'd4, 3'b001);
    end_report("t2a");
    run_window("t2b", 8'd200, 8'd100, 8'd12, 10'd800, 10'd400, 8'd12, 3'b011);
    end_report("t2b");
    run_window("t2c", 8'd128, 8'd50, 8'd3, 10'd512, 10'd200, 8'd4, 3'b100);
    end_report("t2c");
    run_window("t2d", 8'd100, 8'd100, 8'd8, 10'd400, 10'd400, 8'd8, 3'b001);
    end_report("t2d");
    run_window("t5", 8'd255, 8'd255, 8'd255, 10'd1020, 10'd1020, 8'd255, 3'b011);
    end_report("t5");

    // held report with a dropped strobe
    run_window("t3", 8'd128, 8'd100, 8'd3, 10'd512, 10'd400, 8'd4, 3'b000);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", rpt_valid, 1);
      check("t3_hold_ones", rpt_ones_sum, 512);
      check("t3_hold_chg", rpt_chg_sum, 400);
      if (i == 3) begin
        ones = 8'd255; stat_valid = 1'b1;
      end
      tick();
      stat_valid = 1'b0;
    end
    check("t3_overrun", overrun, 1);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    check("t3_drop", rpt_valid, 0);
    check("t3_overrun_kept", overrun, 1);
`ifdef STAT_WIN_AUTO_RESTART_EN
    check("t3_restart_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`else
    check("t3_idle", busy, 0);
`endif
    pulse_start();
    check("t3_overrun_clr", overrun, 0);

    // start ignored mid-window, then reset mid-window
    strobe(8'd10, 8'd10, 8'd1, 8'd1);
    strobe(8'd10, 8'd10, 8'd1, 8'd1);
    check("t4_cnt2", word_cnt, 2);
    pulse_start();
    check("t4_cnt_after_start", word_cnt, 2);
    check("t4_state", dbg_state, 1);
    strobe(8'd10, 8'd10, 8'd1, 8'd1);
    check("t4_cnt3", word_cnt, 3);
    rst_n = 1'b0;
    #1;
    check("t4_rst_busy", busy, 0);
    check("t4_rst_cnt", word_cnt, 0);
    check("t4_rst_ones", rpt_ones_sum, 0);
    check("t4_rst_state", dbg_state, 0);
    tick();
    rst_n = 1'b1;
    strobe(8'd10, 8'd10, 8'd1, 8'd1);
    check("t4_idle_cnt", word_cnt, 0);
    check("t4_idle_busy", busy, 0);
    check("t4_idle_overrun", overrun, 0);

    // back-to-back windows only with auto restart
    run_window("t6", 8'd128, 8'd100, 8'd3, 10'd512, 10'd400, 8'd4, 3'b000);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    strobe(8'd120, 8'd90, 8'd2, 8'd5);
`ifdef STAT_WIN_AUTO_RESTART_EN
    check("t6_cnt1", word_cnt, 1);
`else
    check("t6_cnt1", word_cnt, 0);
`endif
    for (int w = 0; w < 3; w++) strobe(8'd120, 8'd90, 8'd2, 8'd5);
    tick();
`ifdef STAT_WIN_AUTO_RESTART_EN
    check("t6_second_valid", rpt_valid, 1);
    check("t6_second_ones", rpt_ones_sum, 480);
    check("t6_second_chg", rpt_chg_sum, 360);
    check("t6_second_max", rpt_max_run, 5);
`else
    check("t6_second_valid", rpt_valid, 0);
    check("t6_idle", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
